// File: rtl/avr_serial_tx_fifo_if.sv
// Byte-write side of the buffered AVR serial transmitter: strobe, data and
// the queue status that user logic needs in order to pace its writes.
interface avr_serial_tx_fifo_if #(
  parameter int FIFO_AW = 4
);
  logic [7:0]       tx_data;
  logic             new_tx_data;
  logic             tx_busy;
  logic             overflow;
  logic [FIFO_AW:0] fifo_count;
  logic             idle;

  modport master (
    output tx_data, new_tx_data,
    input  tx_busy, overflow, fifo_count, idle
  );

  modport slave (
    input  tx_data, new_tx_data,
    output tx_busy, overflow, fifo_count, idle
  );
endinterface

// File: rtl/avr_serial_tx_fifo.sv
// Buffered 8N1 UART transmitter towards the AVR: a byte FIFO feeding a
// start/data/stop shifter that holds off new frames while the AVR is full.
module avr_serial_tx_fifo #(
  parameter int CLK_PER_BIT = 100,
  parameter int FIFO_AW     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  avr_serial_tx_fifo_if.slave  wr,
  input  logic                 tx_block,
  output logic                 tx
);

  localparam int               DEPTH     = 1 << FIFO_AW;
  localparam int               BAUD_W    = $clog2(CLK_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
  localparam logic [FIFO_AW:0] FULL      = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] CNT_ONE   = (FIFO_AW + 1)'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t             state_r;
  logic [BAUD_W-1:0]  baud_r;
  logic [2:0]         bit_idx_r;
  logic [7:0]         shift_r;
  logic               tx_r;
  logic               blk_meta_r;
  logic               blk_sync_r;
  logic [7:0]         mem_r [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r;
  logic [FIFO_AW-1:0] rd_ptr_r;
  logic [FIFO_AW:0]   count_r;
  logic [FIFO_AW:0]   count_nxt_s;
  logic               tx_busy_r;
  logic               overflow_r;
  logic               write_s;
  logic               pop_s;
  logic               baud_end_s;

  // Write acceptance, frame-start pop decision and next queue occupancy
  always_comb begin
    baud_end_s  = (baud_r == BAUD_LAST);
    write_s     = wr.new_tx_data && !tx_busy_r;
    pop_s       = 1'b0;
    count_nxt_s = count_r;
    if ((count_r != '0) && !blk_sync_r) begin
      case (state_r)
        ST_IDLE: pop_s = 1'b1;
        ST_STOP: pop_s = baud_end_s;
        default: pop_s = 1'b0;
      endcase
    end else begin
      pop_s = 1'b0;
    end
    case ({write_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Two-flop synchronizer for the AVR's asynchronous buffer-full flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_meta_r <= 1'b0;
      blk_sync_r <= 1'b0;
    end else begin
      blk_meta_r <= tx_block;
      blk_sync_r <= blk_meta_r;
    end
  end

  // Byte queue storage, pointers, occupancy and write-side status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      tx_busy_r  <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (write_s) begin
        mem_r[wr_ptr_r] <= wr.tx_data;
        wr_ptr_r        <= wr_ptr_r + FIFO_AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + FIFO_AW'(1'b1);
      end
      count_r    <= count_nxt_s;
      // A same-cycle pop never frees a slot for this write: busy is a flop.
      tx_busy_r  <= (count_nxt_s == FULL);
      overflow_r <= wr.new_tx_data && tx_busy_r;
    end
  end

  // Frame sequencer; tx is registered from the current state, so the line
  // follows the state by one clock while every bit keeps its full length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      baud_r    <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      tx_r      <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tx_r   <= 1'b1;
          baud_r <= '0;
          if (pop_s) begin
            shift_r <= mem_r[rd_ptr_r];
            state_r <= ST_START;
          end
        end
        ST_START: begin
          tx_r <= 1'b0;
          if (baud_end_s) begin
            baud_r    <= '0;
            bit_idx_r <= 3'd0;
            state_r   <= ST_DATA;
          end else begin
            baud_r <= baud_r + BAUD_W'(1'b1);
          end
        end
        ST_DATA: begin
          tx_r <= shift_r[0];
          if (baud_end_s) begin
            baud_r  <= '0;
            shift_r <= {1'b0, shift_r[7:1]};
            if (bit_idx_r == 3'd7) begin
              state_r <= ST_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            baud_r <= baud_r + BAUD_W'(1'b1);
          end
        end
        ST_STOP: begin
          tx_r <= 1'b1;
          if (baud_end_s) begin
            baud_r <= '0;
            if (pop_s) begin
              shift_r <= mem_r[rd_ptr_r];
              state_r <= ST_START;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            baud_r <= baud_r + BAUD_W'(1'b1);
          end
        end
        default: begin
          tx_r    <= 1'b1;
          baud_r  <= '0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx            = tx_r;
  assign wr.tx_busy    = tx_busy_r;
  assign wr.overflow   = overflow_r;
  assign wr.fifo_count = count_r;
  assign wr.idle       = (state_r == ST_IDLE) && (count_r == '0);

endmodule

// File: tb/tb_avr_serial_tx_fifo.sv
// Directed bench for the buffered AVR serial transmitter, run at 4 clocks
// per bit so whole frames can be checked edge by edge.
module tb_avr_serial_tx_fifo;

  logic clk;
  logic rst;
  logic tx_block;
  logic tx;
  int   n_cmp;
  int   n_err;
  logic [39:0] cap_pat [16];

  avr_serial_tx_fifo_if #(.FIFO_AW(4)) bus ();

  avr_serial_tx_fifo #(.CLK_PER_BIT(4), .FIFO_AW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr       (bus),
    .tx_block (tx_block),
    .tx       (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line levels of one 8N1 frame at 4 clocks per bit, index = clock
  function automatic logic [39:0] exp_frame(input logic [7:0] b);
    logic [39:0] p;
    for (int c = 0; c < 40; c++) begin
      if (c < 4)       p[c] = 1'b0;
      else if (c < 36) p[c] = b[(c - 4) / 4];
      else             p[c] = 1'b1;
    end
    return p;
  endfunction

  // Waits for a start bit, then records nf contiguous frames clock by clock
  task automatic capture(input int nf, input int limit, output int waited, output bit tmo);
    waited = 0;
    tmo    = 1'b0;
    while (tx !== 1'b0 && waited < limit) begin
      tick();
      waited++;
    end
    if (tx !== 1'b0) begin
      tmo = 1'b1;
      return;
    end
    for (int k = 0; k < nf * 40; k++) begin
      if (k > 0) tick();
      cap_pat[k / 40][k % 40] = tx;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_block = 1'b0; bus.new_tx_data = 1'b0; bus.tx_data = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_cmp++; if (bus.tx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.tx_busy); end
    n_cmp++; if (bus.fifo_count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", bus.fifo_count); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
    n_cmp++; if (bus.idle !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b expected 1", bus.idle); end
  endtask

  task automatic test_single_byte();
    logic [39:0] pat;
    logic        exp_tx;
    pat = exp_frame(8'h48);
    bus.tx_data = 8'h48; bus.new_tx_data = 1'b1;
    tick();  // write edge 0
    bus.new_tx_data = 1'b0;
    n_cmp++; if (bus.fifo_count !== 5'd1) begin n_err++; $display("FAIL single_count: got %0d expected 1", bus.fifo_count); end
    n_cmp++; if (bus.idle !== 1'b0) begin n_err++; $display("FAIL single_idle_busy: got %b expected 0", bus.idle); end
    for (int e = 1; e <= 42; e++) begin
      tick();
      exp_tx = (e >= 2 && e <= 41) ? pat[e - 2] : 1'b1;
      n_cmp++;
      if (tx !== exp_tx) begin n_err++; $display("FAIL single_tx edge %0d: got %b expected %b", e, tx, exp_tx); end
      if (e == 40) begin
        n_cmp++; if (bus.idle !== 1'b0) begin n_err++; $display("FAIL single_idle_40: got %b expected 0", bus.idle); end
      end
      if (e == 41) begin
        n_cmp++; if (bus.idle !== 1'b1) begin n_err++; $display("FAIL single_idle_41: got %b expected 1", bus.idle); end
      end
    end
  endtask

  task automatic test_back_to_back();
    string       msg;
    logic [39:0] got [12];
    int          busy_seen;
    int          ovf_seen;
    msg = "Hello World!";
    busy_seen = 0; ovf_seen = 0;
    bus.tx_data = msg[0]; bus.new_tx_data = 1'b1;
    for (int e = 0; e <= 481; e++) begin
      tick();
      if (bus.tx_busy !== 1'b0) busy_seen++;
      if (bus.overflow !== 1'b0) ovf_seen++;
      if (e >= 2) got[(e - 2) / 40][(e - 2) % 40] = tx;
      if (e + 1 < 12) bus.tx_data = msg[e + 1];
      else bus.new_tx_data = 1'b0;
    end
    for (int f = 0; f < 12; f++) begin
      n_cmp++;
      if (got[f] !== exp_frame(msg[f]))
        begin n_err++; $display("FAIL hello_frame[%0d]: got %h expected %h", f, got[f], exp_frame(msg[f])); end
    end
    n_cmp++; if (busy_seen != 0) begin n_err++; $display("FAIL hello_busy: got %0d cycles expected 0", busy_seen); end
    n_cmp++; if (ovf_seen != 0) begin n_err++; $display("FAIL hello_overflow: got %0d pulses expected 0", ovf_seen); end
    tick();
    n_cmp++; if (bus.idle !== 1'b1) begin n_err++; $display("FAIL hello_idle_end: got %b expected 1", bus.idle); end
  endtask

  task automatic test_block_full();
    int low_seen;
    int ovf_seen;
    int waited;
    bit tmo;
    low_seen = 0; ovf_seen = 0;
    tx_block = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 17; i++) begin
      bus.tx_data = 8'(8'h10 + i); bus.new_tx_data = 1'b1;
      tick();
      if (tx !== 1'b1) low_seen++;
      if (bus.overflow === 1'b1) ovf_seen++;
      if (i == 16) begin
        n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL full_ovf_17th: got %b expected 1", bus.overflow); end
      end
    end
    bus.new_tx_data = 1'b0;
    repeat (5) begin
      tick();
      if (tx !== 1'b1) low_seen++;
      if (bus.overflow === 1'b1) ovf_seen++;
    end
    n_cmp++; if (ovf_seen != 1) begin n_err++; $display("FAIL full_ovf_pulses: got %0d expected 1", ovf_seen); end
    n_cmp++; if (low_seen != 0) begin n_err++; $display("FAIL full_tx_held: got %0d low cycles expected 0", low_seen); end
    n_cmp++; if (bus.fifo_count !== 5'd16) begin n_err++; $display("FAIL full_count: got %0d expected 16", bus.fifo_count); end
    n_cmp++; if (bus.tx_busy !== 1'b1) begin n_err++; $display("FAIL full_busy: got %b expected 1", bus.tx_busy); end
    // Synchronizer takes two edges, pop on the third, line falls on the fourth
    tx_block = 1'b0;
    capture(16, 10, waited, tmo);
    n_cmp++; if (tmo || waited != 4) begin n_err++; $display("FAIL full_release_latency: got %0d (timeout %0d) expected 4", waited, tmo); end
    for (int f = 0; f < 16; f++) begin
      n_cmp++;
      if (cap_pat[f] !== exp_frame(8'(8'h10 + f)))
        begin n_err++; $display("FAIL full_frame[%0d]: got %h expected %h", f, cap_pat[f], exp_frame(8'(8'h10 + f))); end
    end
    tick();
    n_cmp++; if (bus.idle !== 1'b1 || bus.fifo_count !== 5'd0)
      begin n_err++; $display("FAIL full_drained: got idle=%b count=%0d expected idle=1 count=0", bus.idle, bus.fifo_count); end
  endtask

  task automatic test_block_midframe();
    logic [7:0]  bytes [3];
    logic [39:0] first;
    int          low_seen;
    int          waited;
    bit          tmo;
    bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'h81;
    low_seen = 0;
    bus.tx_data = bytes[0]; bus.new_tx_data = 1'b1;
    for (int e = 0; e <= 41; e++) begin
      tick();
      if (e >= 2) first[e - 2] = tx;
      if (e + 1 < 3) bus.tx_data = bytes[e + 1];
      else bus.new_tx_data = 1'b0;
      if (e == 20) tx_block = 1'b1;
    end
    n_cmp++; if (first !== exp_frame(bytes[0])) begin n_err++; $display("FAIL mid_frame1: got %h expected %h", first, exp_frame(bytes[0])); end
    repeat (20) begin
      tick();
      if (tx !== 1'b1) low_seen++;
    end
    n_cmp++; if (low_seen != 0) begin n_err++; $display("FAIL mid_held: got %0d low cycles expected 0", low_seen); end
    n_cmp++; if (bus.fifo_count !== 5'd2) begin n_err++; $display("FAIL mid_count: got %0d expected 2", bus.fifo_count); end
    n_cmp++; if (bus.idle !== 1'b0) begin n_err++; $display("FAIL mid_idle: got %b expected 0", bus.idle); end
    tx_block = 1'b0;
    capture(2, 10, waited, tmo);
    n_cmp++; if (tmo) begin n_err++; $display("FAIL mid_release: got timeout expected start bit"); end
    for (int f = 0; f < 2; f++) begin
      n_cmp++;
      if (cap_pat[f] !== exp_frame(bytes[f + 1]))
        begin n_err++; $display("FAIL mid_frame[%0d]: got %h expected %h", f + 2, cap_pat[f], exp_frame(bytes[f + 1])); end
    end
    tick();
    n_cmp++; if (bus.idle !== 1'b1) begin n_err++; $display("FAIL mid_idle_end: got %b expected 1", bus.idle); end
  endtask

  task automatic test_reset_midframe();
    int low_seen;
    low_seen = 0;
    bus.tx_data = 8'h00; bus.new_tx_data = 1'b1;
    for (int e = 0; e <= 15; e++) begin
      tick();
      if (e + 1 < 5) bus.tx_data = 8'(8'h11 * (e + 1));
      else bus.new_tx_data = 1'b0;
    end
    // Edge 15 sits in data bit 2 of byte 0x00, so the line is low here
    n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL rst_pre_tx: got %b expected 0", tx); end
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL rst_async_tx: got %b expected 1", tx); end
    n_cmp++; if (bus.fifo_count !== 5'd0) begin n_err++; $display("FAIL rst_async_count: got %0d expected 0", bus.fifo_count); end
    n_cmp++; if (bus.idle !== 1'b1) begin n_err++; $display("FAIL rst_async_idle: got %b expected 1", bus.idle); end
    #10 rst = 1'b0;
    repeat (100) begin
      tick();
      if (tx !== 1'b1) low_seen++;
    end
    n_cmp++; if (low_seen != 0) begin n_err++; $display("FAIL rst_no_frames: got %0d low cycles expected 0", low_seen); end
  endtask

  task automatic test_full_stop_edge();
    int waited;
    tx_block = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 16; i++) begin
      bus.tx_data = 8'(8'h60 + i); bus.new_tx_data = 1'b1;
      tick();
    end
    bus.new_tx_data = 1'b0;
    tick();
    n_cmp++; if (bus.fifo_count !== 5'd16 || bus.tx_busy !== 1'b1)
      begin n_err++; $display("FAIL edge_fill: got count=%0d busy=%b expected 16/1", bus.fifo_count, bus.tx_busy); end
    tx_block = 1'b0;
    waited = 0;
    while (tx !== 1'b0 && waited < 10) begin tick(); waited++; end
    n_cmp++;
    if (tx !== 1'b0) begin
      n_err++; $display("FAIL edge_start: got timeout expected start bit");
      return;
    end
    // Start bit first seen at edge S; this frame's pop was S-1, next pop is S+39
    bus.tx_data = 8'h70; bus.new_tx_data = 1'b1;
    tick();
    bus.new_tx_data = 1'b0;
    n_cmp++; if (bus.fifo_count !== 5'd16 || bus.tx_busy !== 1'b1)
      begin n_err++; $display("FAIL edge_refill: got count=%0d busy=%b expected 16/1", bus.fifo_count, bus.tx_busy); end
    repeat (37) tick();
    bus.tx_data = 8'h71; bus.new_tx_data = 1'b1;
    tick();
    n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL edge_overflow: got %b expected 1", bus.overflow); end
    n_cmp++; if (bus.fifo_count !== 5'd15) begin n_err++; $display("FAIL edge_count_pop: got %0d expected 15", bus.fifo_count); end
    n_cmp++; if (bus.tx_busy !== 1'b0) begin n_err++; $display("FAIL edge_busy_pop: got %b expected 0", bus.tx_busy); end
    bus.tx_data = 8'h72;
    tick();
    bus.new_tx_data = 1'b0;
    n_cmp++; if (bus.fifo_count !== 5'd16) begin n_err++; $display("FAIL edge_count_next: got %0d expected 16", bus.fifo_count); end
    n_cmp++; if (bus.tx_busy !== 1'b1) begin n_err++; $display("FAIL edge_busy_next: got %b expected 1", bus.tx_busy); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL edge_overflow_next: got %b expected 0", bus.overflow); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_block_full();
    test_block_midframe();
    test_reset_midframe();
    test_full_stop_edge();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
